// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: opcodes, counter encodings
// and the default PC slicing geometry used by the branch target buffer.
package bp_pkg;

    localparam int BTB_IDX_W = 4;
    localparam int BTB_PC_W  = 32;
    localparam int BTB_CNT_W = 16;
    localparam int BTB_ENTRIES = 1 << BTB_IDX_W;
    // Word-aligned PCs: index sits just above the two byte-offset bits.
    localparam int BTB_IDX_LSB = 2;
    localparam int BTB_TAG_LSB = BTB_IDX_W + BTB_IDX_LSB;
    localparam int BTB_TAG_W   = BTB_PC_W - BTB_TAG_LSB;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    typedef enum logic [1:0] {
        CNT_SNT = 2'd0,
        CNT_WNT = 2'd1,
        CNT_WT  = 2'd2,
        CNT_ST  = 2'd3
    } cnt_e;

    localparam cnt_e CNT_ALLOC = CNT_WT;
    localparam cnt_e CNT_RESET = CNT_WNT;

    function automatic logic is_cond_branch(input logic [5:0] opcode);
        return (opcode == OP_BEQ) || (opcode == OP_BNE);
    endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch-side lookup and ID-side update bundle of the branch target buffer.
interface branch_target_buffer_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) ();
    logic              stall;
    logic [PC_W-1:0]   if_pc;
    logic              if_is_branch;
    logic              hit;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_next_pc;
    logic              upd_valid;
    logic [PC_W-1:0]   upd_pc;
    logic              upd_taken;
    logic [PC_W-1:0]   upd_target;
    logic              upd_mispredict;
    logic [CNT_W-1:0]  mispredict_cnt;

    modport master (
        output stall, if_pc, if_is_branch,
        output upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        input  hit, pred_taken, pred_next_pc, mispredict_cnt
    );

    modport slave (
        input  stall, if_pc, if_is_branch,
        input  upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        output hit, pred_taken, pred_next_pc, mispredict_cnt
    );
endinterface

// File: rtl/bp_sat_counter.sv
// Two-bit saturating taken/not-taken counter next-state logic.
module bp_sat_counter
    import bp_pkg::*;
(
    input  cnt_e cnt,
    input  logic taken,
    output cnt_e cnt_next
);
    always_comb begin
        cnt_next = cnt;
        unique case (cnt)
            CNT_SNT: cnt_next = taken ? CNT_WNT : CNT_SNT;
            CNT_WNT: cnt_next = taken ? CNT_WT  : CNT_SNT;
            CNT_WT:  cnt_next = taken ? CNT_ST  : CNT_WNT;
            CNT_ST:  cnt_next = taken ? CNT_ST  : CNT_WT;
            default: cnt_next = cnt;
        endcase
    end
endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: zero-latency lookup of the fetch PC,
// registered update from the resolved BEQ/BNE outcome in ID.
module branch_target_buffer
    import bp_pkg::*;
#(
    parameter int IDX_W = BTB_IDX_W,
    parameter int PC_W  = BTB_PC_W,
    parameter int CNT_W = BTB_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    branch_target_buffer_if.slave bus
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_LSB = IDX_W + BTB_IDX_LSB;
    localparam int TAG_W   = PC_W - TAG_LSB;

    logic             valid_reg  [ENTRIES];
    logic [TAG_W-1:0] tag_reg    [ENTRIES];
    logic [PC_W-1:0]  target_reg [ENTRIES];
    logic [1:0]       cnt_reg    [ENTRIES];
    logic [CNT_W-1:0] mispredict_cnt_reg;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit, upd_en;
    cnt_e             up_cnt_next;
    logic             unused_byte_offsets;

    assign lk_idx = bus.if_pc[TAG_LSB-1:BTB_IDX_LSB];
    assign lk_tag = bus.if_pc[PC_W-1:TAG_LSB];
    assign up_idx = bus.upd_pc[TAG_LSB-1:BTB_IDX_LSB];
    assign up_tag = bus.upd_pc[PC_W-1:TAG_LSB];
    assign unused_byte_offsets = ^{bus.if_pc[1:0], bus.upd_pc[1:0]};

    // Lookup reads the registered table, so a same-cycle update is seen next cycle.
    assign bus.hit          = bus.if_is_branch & valid_reg[lk_idx] & (tag_reg[lk_idx] == lk_tag);
    assign bus.pred_taken   = bus.hit & cnt_reg[lk_idx][1];
    assign bus.pred_next_pc = bus.pred_taken ? target_reg[lk_idx] : bus.if_pc + PC_W'(4);
    assign bus.mispredict_cnt = mispredict_cnt_reg;

    assign upd_en = bus.upd_valid & ~bus.stall;
    assign up_hit = valid_reg[up_idx] & (tag_reg[up_idx] == up_tag);

    bp_sat_counter u_sat_counter (
        .cnt      (cnt_e'(cnt_reg[up_idx])),
        .taken    (bus.upd_taken),
        .cnt_next (up_cnt_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_reg[i] <= 1'b0;
                cnt_reg[i]   <= CNT_RESET;
            end
        end else if (upd_en) begin
            if (up_hit) begin
                cnt_reg[up_idx] <= up_cnt_next;
                if (bus.upd_taken)
                    target_reg[up_idx] <= bus.upd_target;
            end else if (bus.upd_taken) begin
                // Taken miss evicts whatever occupied the slot.
                valid_reg[up_idx]  <= 1'b1;
                tag_reg[up_idx]    <= up_tag;
                target_reg[up_idx] <= bus.upd_target;
                cnt_reg[up_idx]    <= CNT_ALLOC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            mispredict_cnt_reg <= '0;
        else if (upd_en && bus.upd_mispredict && (mispredict_cnt_reg != {CNT_W{1'b1}}))
            mispredict_cnt_reg <= mispredict_cnt_reg + CNT_W'(1);
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer with hand-computed expectations.
module tb_branch_target_buffer;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    branch_target_buffer_if #(.PC_W(32), .CNT_W(16)) bus ();

    branch_target_buffer #(.IDX_W(4), .PC_W(32), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic br,
                          input logic exp_hit, input logic exp_taken, input logic [31:0] exp_npc);
        bus.if_pc = pc;
        bus.if_is_branch = br;
        #1;
        check({tag, ".hit"}, {31'd0, bus.hit}, {31'd0, exp_hit});
        check({tag, ".taken"}, {31'd0, bus.pred_taken}, {31'd0, exp_taken});
        check({tag, ".npc"}, bus.pred_next_pc, exp_npc);
        $display("lookup %s pc=%h hit=%0b taken=%0b npc=%h", tag, pc, bus.hit, bus.pred_taken, bus.pred_next_pc);
    endtask

    task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] target, input logic mis);
        bus.upd_valid = 1'b1;
        bus.upd_pc = pc;
        bus.upd_taken = taken;
        bus.upd_target = target;
        bus.upd_mispredict = mis;
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
        bus.upd_mispredict = 1'b0;
        $display("update pc=%h taken=%0b target=%h mis=%0b stall=%0b", pc, taken, target, mis, bus.stall);
    endtask

    task automatic check_cnt(input string tag, input logic [15:0] expected);
        check(tag, {16'd0, bus.mispredict_cnt}, {16'd0, expected});
        $display("count %s mispredict_cnt=%h", tag, bus.mispredict_cnt);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.if_pc = 32'h0;
        bus.if_is_branch = 1'b0;
        bus.upd_valid = 1'b0;
        bus.upd_pc = 32'h0;
        bus.upd_taken = 1'b0;
        bus.upd_target = 32'h0;
        bus.upd_mispredict = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        lookup("reset", 32'h40, 1'b1, 1'b0, 1'b0, 32'h44);
        check_cnt("reset_cnt", 16'h0000);

        // Learn 0x40 and walk its counter through the full range.
        update(32'h40, 1'b1, 32'h100, 1'b0);
        lookup("alloc_wt", 32'h40, 1'b1, 1'b1, 1'b1, 32'h100);
        update(32'h40, 1'b1, 32'h100, 1'b0);
        lookup("st", 32'h40, 1'b1, 1'b1, 1'b1, 32'h100);
        update(32'h40, 1'b0, 32'h0, 1'b0);
        lookup("st_to_wt", 32'h40, 1'b1, 1'b1, 1'b1, 32'h100);
        update(32'h40, 1'b0, 32'h0, 1'b0);
        lookup("wnt", 32'h40, 1'b1, 1'b1, 1'b0, 32'h44);
        update(32'h40, 1'b0, 32'h0, 1'b0);
        lookup("snt", 32'h40, 1'b1, 1'b1, 1'b0, 32'h44);
        update(32'h40, 1'b0, 32'h0, 1'b0);
        lookup("snt_sat", 32'h40, 1'b1, 1'b1, 1'b0, 32'h44);
        update(32'h40, 1'b1, 32'h200, 1'b0);
        lookup("snt_to_wnt", 32'h40, 1'b1, 1'b1, 1'b0, 32'h44);
        update(32'h40, 1'b1, 32'h200, 1'b0);
        lookup("new_target", 32'h40, 1'b1, 1'b1, 1'b1, 32'h200);
        lookup("not_branch", 32'h40, 1'b0, 1'b0, 1'b0, 32'h44);

        // 0x80 shares index 0 with 0x40.
        update(32'h80, 1'b1, 32'h300, 1'b0);
        lookup("evicted", 32'h40, 1'b1, 1'b0, 1'b0, 32'h44);
        lookup("alias_new", 32'h80, 1'b1, 1'b1, 1'b1, 32'h300);

        update(32'h48, 1'b0, 32'h999, 1'b0);
        lookup("nt_miss", 32'h48, 1'b1, 1'b0, 1'b0, 32'h4C);

        // Stalled update is ignored.
        bus.stall = 1'b1;
        update(32'h80, 1'b0, 32'h0, 1'b1);
        bus.stall = 1'b0;
        lookup("stall_tbl", 32'h80, 1'b1, 1'b1, 1'b1, 32'h300);
        check_cnt("stall_cnt", 16'h0000);

        // Same-index read during update sees old contents.
        bus.if_pc = 32'h80;
        bus.if_is_branch = 1'b1;
        bus.upd_valid = 1'b1;
        bus.upd_pc = 32'h80;
        bus.upd_taken = 1'b0;
        bus.upd_mispredict = 1'b1;
        lookup("rbw_old", 32'h80, 1'b1, 1'b1, 1'b1, 32'h300);
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
        bus.upd_mispredict = 1'b0;
        lookup("rbw_new", 32'h80, 1'b1, 1'b1, 1'b0, 32'h84);
        check_cnt("cnt_one", 16'h0001);

        // Top index with an all-ones tag; fall-through wraps to zero.
        update(32'hFFFF_FFFC, 1'b1, 32'h1234, 1'b0);
        lookup("top_entry", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 32'h1234);
        lookup("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0000_0000);

        // Drive the counter to saturation with not-taken misses at 0x48.
        bus.upd_valid = 1'b1;
        bus.upd_pc = 32'h48;
        bus.upd_taken = 1'b0;
        bus.upd_mispredict = 1'b1;
        repeat (65533) @(posedge clk);
        #1;
        check_cnt("cnt_fffe", 16'hFFFE);
        @(posedge clk);
        #1;
        check_cnt("cnt_ffff", 16'hFFFF);
        @(posedge clk);
        #1;
        check_cnt("cnt_sat", 16'hFFFF);
        lookup("sat_nt_miss", 32'h48, 1'b1, 1'b0, 1'b0, 32'h4C);

        // Reset wins over a concurrent allocating update.
        rst_n = 1'b0;
        bus.upd_pc = 32'h40;
        bus.upd_taken = 1'b1;
        bus.upd_target = 32'h500;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.upd_valid = 1'b0;
        bus.upd_mispredict = 1'b0;
        lookup("rst_40", 32'h40, 1'b1, 1'b0, 1'b0, 32'h44);
        lookup("rst_80", 32'h80, 1'b1, 1'b0, 1'b0, 32'h84);
        lookup("rst_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
        check_cnt("rst_cnt", 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- PC-indexed, direct-mapped branch target buffer with a per-entry 2-bit saturating counter.
- Sits in IF, directly upstream of the PC mux and the ID-stage prediction check.
- Looks up the current fetch PC and supplies hit, the taken prediction and the predicted next PC.
- Receives the resolved outcome of BEQ/BNE from ID and updates its table.

Parameters:
- IDX_W, 4, index bits; ENTRIES = 2**IDX_W = 16.
- PC_W, 32, PC/target width.
- CNT_W, 16, width of the saturating mispredict performance counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  pipeline stall; blocks table updates and counter increments.
- if_pc  in  PC_W  current fetch PC.
- if_is_branch  in  1  IF opcode is BEQ (000100) or BNE (000101).
- hit  out  1  valid entry with matching tag for if_pc.
- pred_taken  out  1  prediction to take the branch.
- pred_next_pc  out  PC_W  predicted fetch address.
- upd_valid  in  1  ID resolved a BEQ/BNE this cycle.
- upd_pc  in  PC_W  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  PC_W  computed branch target.
- upd_mispredict  in  1  ID prediction check flagged the prediction wrong.
- mispredict_cnt  out  CNT_W  saturating count of mispredicts.

Behaviour:
- Address split:
  - idx = pc[IDX_W+1:2].
  - tag = pc[PC_W-1:IDX_W+2].
  - pc[1:0] is ignored.
- Per-entry storage: valid (1), tag, target (PC_W), cnt (2).
- Counter encoding: 0 SNT, 1 WNT, 2 WT, 3 ST. Prediction is cnt[1].
- Lookup (combinational, zero latency):
  - hit = if_is_branch & valid[idx] & (tag[idx] == tag(if_pc)).
  - pred_taken = hit & cnt[idx][1].
  - pred_next_pc = pred_taken ? target[idx] : if_pc + 4, mod 2^PC_W (wraps at 0xFFFFFFFC -> 0x0).
  - if_is_branch = 0 forces hit = 0 and pred_taken = 0.
- Update (registered; takes effect at the posedge where upd_valid & !stall):
  - Hit on upd_pc:
    - taken: cnt = min(cnt+1, 3) and target overwritten with upd_target.
    - not taken: cnt = max(cnt-1, 0); target unchanged.
  - Miss on upd_pc:
    - taken: allocate (replace any existing entry): valid=1, tag, target=upd_target, cnt=2 (WT).
    - not taken: table unchanged; no allocation.
  - Saturation: ST + taken stays 3; SNT + not taken stays 0.
- Mispredict counter:
  - Increments on upd_valid & upd_mispredict & !stall.
  - Saturates at 2^CNT_W-1; never wraps.
- Stall: lookup outputs still track if_pc; no table or counter state changes.
- Same-cycle lookup and update to the same idx: lookup returns the pre-update contents (read-before-write). The new contents are visible from the next cycle.
- upd_valid with upd_mispredict = 0 but a differing outcome is legal: the table follows upd_taken only.
- Reset (rst_n = 0 at a posedge):
  - All valid = 0, all cnt = 1 (WNT); tags/targets don't-care; mispredict_cnt = 0.
  - Resulting outputs: hit = 0, pred_taken = 0, pred_next_pc = if_pc + 4.
  - Reset overrides any concurrent update.
  - Reset mid-operation discards all learned state.

Decomposition:
- Shared package bp_pkg holds:
  - Opcode constants BEQ/BNE.
  - Counter encodings SNT/WNT/WT/ST.
  - Allocation value WT.
  - Index/tag slicing widths derived from IDX_W.
- Sub-module bp_sat_counter: combinational 2-bit saturating next-state (cnt, taken -> cnt_next). Instantiated once on the update path. The table is a flat register array in the top.

Test Plan:
- Reset, then if_pc=0x40 with if_is_branch=1 -> hit=0, pred_taken=0, pred_next_pc=0x44; mispredict_cnt=0.
- Update upd_pc=0x40, taken=1, target=0x100; next cycle lookup 0x40 -> hit=1, pred_taken=1, pred_next_pc=0x100 (cnt=2). Repeat taken -> cnt=3; three not-taken updates -> cnt 2, 1, 0; prediction flips to not-taken after the second, and pred_next_pc=0x44.
- Aliasing: allocate 0x40 (taken), then taken update at 0x80 (same idx 0, different tag) -> lookup 0x40 misses; lookup 0x80 hits with the new target.
- Not-taken update on a miss at 0x48 -> lookup 0x48 still hit=0; no entry is allocated.
- stall=1 with upd_valid=1, upd_mispredict=1 -> table and mispredict_cnt unchanged. Same update with stall=0 and lookup of the same idx in the same cycle -> old value this cycle, new value next cycle; mispredict_cnt +1.
- Force mispredict_cnt to 0xFFFF, apply another mispredict -> stays 0xFFFF. Assert rst_n=0 mid-stream -> all entries miss and count returns to 0.
